// File: rtl/alu_seq.sv
// Sequential ALU: logic/arithmetic ops complete in one edge, shifts run one bit
// per cycle through a small IDLE/SHIFT FSM.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [4:0]       cnt;
  logic [4:0]       k;
  logic [3:0]       sh_op;
  logic [WIDTH-1:0] sh_reg, sh_step;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, is_shift, launch, issue_now;

  assign k         = num2[4:0];
  assign is_shift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign launch    = start && (state == IDLE) && is_shift && (k != 5'd0);
  assign issue_now = start && (state == IDLE) && !launch;
  assign busy      = (state == SHIFT);
  assign sum       = num1 + num2;
  assign diff      = num1 - num2;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND: alu_res = num1 & num2;
      OP_OR:  alu_res = num1 | num2;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (num1[WIDTH-1] == num2[WIDTH-1]) && (sum[WIDTH-1] != num1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (num1[WIDTH-1] != num2[WIDTH-1]) && (diff[WIDTH-1] != num1[WIDTH-1]);
      end
      OP_XOR: alu_res = num1 ^ num2;
      OP_NOR: alu_res = ~(num1 | num2);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
      OP_SLL, OP_SRL, OP_SRA: alu_res = num1;  // only reached with k == 0
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (sh_op)
      OP_SLL:  sh_step = {sh_reg[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_step = {1'b0, sh_reg[WIDTH-1:1]};
      default: sh_step = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = SHIFT;
      SHIFT:   if (cnt == 5'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (issue_now) begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        overflow <= alu_ovf;
        done     <= 1'b1;
      end else if (launch) begin
        cnt <= k;
      end else if (state == SHIFT) begin
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          result   <= sh_step;
          zero     <= (sh_step == '0);
          overflow <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

  // NOTE: the shift datapath has no reset; it is always loaded on launch
  // before it is read, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (launch) begin
      sh_reg <= num1;
      sh_op  <= op;
    end else if (state == SHIFT) begin
      sh_reg <= sh_step;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a reference model pushes expected results to
// a scoreboard that a done-triggered monitor pops and compares.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] num1, num2;
  logic [31:0] result;
  logic        zero, overflow, busy, done;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total  = 0;
  int   bad    = 0;
  int   n_done = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    int     sh;
    sh  = int'(b[4:0]);
    e.v = 1'b0;
    case (o)
      4'd0: e.r = a & b;
      4'd1: e.r = a | b;
      4'd2: begin
        e.r = a + b;
        s   = longint'($signed(a)) + longint'($signed(b));
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        e.r = a - b;
        s   = longint'($signed(a)) - longint'($signed(b));
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: e.r = a ^ b;
      4'd5: e.r = ~(a | b);
      4'd6: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: e.r = a << sh;
      4'd8: e.r = a >> sh;
      4'd9: e.r = $signed(a) >>> sh;
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: result=%h with no pending expectation", result);
      end else begin
        mon_e = sb.pop_front();
        if ({result, zero, overflow, busy} !== {mon_e.r, mon_e.z, mon_e.v, 1'b0}) begin
          bad++;
          $display("FAIL sb_result: got r=%h z=%b v=%b busy=%b, want r=%h z=%b v=%b busy=0",
                   result, zero, overflow, busy, mon_e.r, mon_e.z, mon_e.v);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
    start = 1'b1; op = o; num1 = a; num2 = b;
    if (push) sb.push_back(model(o, a, b));
  endtask

  task automatic wait_done(input int target, input int limit);
    int i = 0;
    while (n_done < target && i < limit) begin
      step();
      i++;
    end
    total++;
    if (n_done < target) begin
      bad++;
      $display("FAIL wait_done: completions=%0d, wanted %0d within %0d cycles", n_done, target, limit);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int n0 = n_done;
    drive(o, a, b, 1'b1);
    step();
    start = 1'b0;
    wait_done(n0 + 1, 40);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; num1 = '0; num2 = '0;
    step(); step();
    total++;
    if ({result, zero, overflow, busy, done} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: r=%h z=%b v=%b busy=%b done=%b, want 0/1/0/0/0",
               result, zero, overflow, busy, done);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_logic();
    drive(4'd1, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1);
    step();
    start = 1'b0;
    total++;
    if ({result, zero, done, busy} !== {32'hF0F0_0F0F, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL or_single_cycle: r=%h z=%b done=%b busy=%b, want f0f00f0f/0/1/0",
               result, zero, done, busy);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle: done=%b, want 0", done);
    end
    issue(4'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
    issue(4'd4, 32'hAAAA_5555, 32'hFFFF_0000);
    issue(4'd5, 32'h0000_0000, 32'h0000_0000);
    issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_arith();
    issue(4'd2, 32'h7FFF_FFFF, 32'd1);
    total++;
    if ({result, overflow} !== {32'h8000_0000, 1'b1}) begin
      bad++;
      $display("FAIL add_overflow: r=%h v=%b, want 80000000/1", result, overflow);
    end
    issue(4'd3, 32'd5, 32'd5);
    total++;
    if ({result, zero, overflow} !== {32'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_zero: r=%h z=%b v=%b, want 0/1/0", result, zero, overflow);
    end
    issue(4'd3, 32'h8000_0000, 32'd1);
    issue(4'd2, 32'hFFFF_FFFF, 32'd1);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd6, 32'd3, 32'hFFFF_FFF0);
  endtask

  // Multi-cycle shift with junk starts and changing operands while busy.
  task automatic do_shift(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int n0 = n_done;
    int kk = int'(b[4:0]);
    int busy_cnt = 0;
    drive(o, a, b, 1'b1);
    for (int i = 1; i <= kk + 1; i++) begin
      step();
      if (i <= kk) begin
        if (busy === 1'b1 && done === 1'b0) busy_cnt++;
        start = 1'b1; op = 4'd2; num1 = $urandom; num2 = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    total++;
    if (busy_cnt != kk || n_done != n0 + 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL shift_timing op=%0d k=%0d: busy_cycles=%0d completions=%0d busy=%b, want %0d/1/0",
               o, kk, busy_cnt, n_done - n0, busy, kk);
    end
    step();
  endtask

  task automatic test_shifts();
    do_shift(4'd9, 32'h8000_0000, 32'd4);
    total++;
    if (result !== 32'hF800_0000) begin
      bad++;
      $display("FAIL sra_fill: r=%h, want f8000000", result);
    end
    issue(4'd7, 32'd1, 32'h0000_0020);
    total++;
    if (result !== 32'd1) begin
      bad++;
      $display("FAIL sll_k0: r=%h, want 1", result);
    end
    do_shift(4'd8, 32'h8000_0000, 32'd31);
    total++;
    if (result !== 32'd1) begin
      bad++;
      $display("FAIL srl_31: r=%h, want 1", result);
    end
    do_shift(4'd7, 32'h8000_0001, 32'hFFFF_FFE1);
    do_shift(4'd9, 32'h4000_0000, 32'd30);
    do_shift(4'd8, 32'hFFFF_FFFF, 32'd1);
  endtask

  task automatic test_back_to_back();
    int n0 = n_done;
    drive(4'd2, 32'd100, 32'd23, 1'b1);
    step();
    total++;
    if (n_done != n0 + 1) begin
      bad++;
      $display("FAIL b2b_first: completions=%0d, want 1", n_done - n0);
    end
    drive(4'd9, 32'hF000_000F, 32'd3, 1'b1);
    step();
    start = 1'b0;
    wait_done(n0 + 2, 40);
    drive(4'd4, 32'h1111_1111, 32'h1111_1111, 1'b1);
    step();
    start = 1'b0;
    wait_done(n0 + 3, 40);
  endtask

  task automatic test_reset_abort();
    int n0;
    drive(4'd8, 32'hDEAD_BEEF, 32'd10, 1'b0);
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    total++;
    if ({result, zero, overflow, busy, done} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_reset: r=%h z=%b v=%b busy=%b done=%b, want 0/1/0/0/0",
               result, zero, overflow, busy, done);
    end
    rst = 1'b0;
    n0 = n_done;
    repeat (12) step();
    total++;
    if (n_done != n0) begin
      bad++;
      $display("FAIL abort_no_done: completions=%0d, want 0", n_done - n0);
    end
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    total++;
    if (result !== 32'd1) begin
      bad++;
      $display("FAIL slt_after_abort: r=%h, want 1", result);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 15)), $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_shifts();
    test_back_to_back();
    test_reset_abort();
    test_random();
    repeat (3) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand/result width; only 32 is supported.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation; sampled on a rising edge.
REQ-005 The module SHALL have port op, input, 4 bits: operation code, sampled with start.
REQ-006 The module SHALL have ports num1 and num2, input, 32 bits each: operands, sampled with start.
REQ-007 The module SHALL have port result, output, 32 bits: registered result of the last completed operation.
REQ-008 The module SHALL have port zero, output, 1 bit: registered flag, result equals 0.
REQ-009 The module SHALL have port overflow, output, 1 bit: registered signed-overflow flag.
REQ-010 The module SHALL have port busy, output, 1 bit: high while a multi-cycle shift is in progress.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.

Function
REQ-012 op codes SHALL be: 0 AND, 1 OR (bitwise num1|num2), 2 ADD, 3 SUB (num1-num2), 4 XOR, 5 NOR, 6 SLT (signed; result 1 or 0), 7 SLL, 8 SRL, 9 SRA.
REQ-013 The FSM SHALL have states IDLE and SHIFT; start is accepted only in IDLE, and start while busy=1 SHALL be ignored with no effect.
REQ-014 For op 0-6, op 10-15, and shifts with num2[4:0]=0, start accepted at edge N SHALL update result, zero and overflow at edge N, and done SHALL be 1 for exactly the following cycle; the FSM SHALL stay in IDLE.
REQ-015 Shifts SHALL use num2[4:0] as shift amount k and num1 as the shifted value; bits num2[31:5] SHALL be ignored.
REQ-016 For k>0, edge N SHALL load the shift register with num1 and the counter with k, and the FSM SHALL enter SHIFT.
REQ-017 In SHIFT, each edge SHALL shift by one bit and decrement the counter; SLL SHALL fill with 0, SRL SHALL fill with 0, and SRA SHALL fill with bit 31 of the shifted value.
REQ-018 The edge that performs the k-th shift SHALL be edge N+k; it SHALL write result and flags, pulse done in the next cycle, and return the FSM to IDLE.
REQ-019 busy SHALL be 1 from the cycle after edge N through edge N+k, and 0 in the cycle where done=1.
REQ-020 A new start SHALL be accepted in the same cycle that done=1, allowing back-to-back issue.
REQ-021 ADD and SUB SHALL wrap modulo 2^32; overflow SHALL equal signed two's-complement overflow for ADD and SUB, and SHALL be 0 for all other ops.
REQ-022 Undefined op codes 10-15 SHALL produce result 0, zero=1 and overflow=0.
REQ-023 zero SHALL be computed from the value written into result and updated in the same edge as result.
REQ-024 result, zero and overflow SHALL hold their values between completions; operand changes while busy SHALL NOT affect an operation in flight.

Reset
REQ-025 While rst=1 at an edge, the FSM SHALL go to IDLE, result SHALL be 0, zero SHALL be 1, overflow SHALL be 0, busy SHALL be 0, done SHALL be 0, and the counter SHALL be 0.
REQ-026 rst SHALL take priority over start and over an in-progress shift; an aborted shift SHALL produce no done pulse.

Verification
REQ-027 op=1, num1=0xF0F0_0000, num2=0x0000_0F0F, start for 1 cycle -> next cycle result=0xF0F0_0F0F, zero=0, done=1 for one cycle, busy=0.
REQ-028 op=2, num1=0x7FFF_FFFF, num2=1 -> result=0x8000_0000, overflow=1; then op=3, num1=5, num2=5 -> result=0, zero=1, overflow=0.
REQ-029 op=9, num1=0x8000_0000, num2=4 -> busy=1 for 4 cycles, start pulses during busy are ignored, then result=0xF800_0000 with done pulsed once.
REQ-030 op=7, num1=1, num2=0x20 (k=0) -> single-cycle completion, result=1; then op=8, num1=0x8000_0000, num2=31 -> result=1 after 31 busy cycles.
REQ-031 op=8 with k=10, rst asserted at the 3rd busy cycle -> at the next edge all outputs are at reset values, no done pulse occurs, and a subsequent op=6 with num1=0xFFFF_FFFF, num2=0 gives result=1.
